// File: rtl/act_track_arbiter_if.sv
// Bundle between the bank command queues, the ACT arbiter and the RowHammer tracker.
// master: arbiter side; slave: requester/tracker environment side.
interface act_track_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ROW_W  = 16,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned CNT_W  = 32
);
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*ROW_W-1:0] req_row_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   trk_act_o;
  logic [ROW_W-1:0]       trk_row_o;
  logic [BANK_W-1:0]      trk_bank_o;
  logic                   trk_done_i;
  logic [N_REQ-1:0]       grant_o;
  logic                   busy_o;
  logic [CNT_W-1:0]       act_cnt_o;
  logic                   timeout_o;

  modport master (
    input  req_valid_i, req_row_i, trk_done_i,
    output req_ready_o, trk_act_o, trk_row_o, trk_bank_o, grant_o, busy_o,
           act_cnt_o, timeout_o
  );

  modport slave (
    output req_valid_i, req_row_i, trk_done_i,
    input  req_ready_o, trk_act_o, trk_row_o, trk_bank_o, grant_o, busy_o,
           act_cnt_o, timeout_o
  );
endinterface

// File: rtl/act_track_arbiter.sv
// Round-robin arbiter sharing one RowHammer tracker among N_REQ bank ACT requesters.
// Optional WAIT-state abort enabled by defining ACT_ARB_TIMEOUT_EN.
module act_track_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ROW_W   = 16,
  parameter int unsigned BANK_W  = 2,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  act_track_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  if (N_REQ < 2) begin : g_chk_nreq
    $error("act_track_arbiter: N_REQ must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("act_track_arbiter: TIMEOUT must be >= 1");
  end

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   ptr_q, ptr_d;
  logic [BANK_W-1:0]   win_idx;
  logic                win_found;
  logic [ROW_W-1:0]    win_row;
  logic [N_REQ-1:0]    ready_c;
  logic                xfer;
  logic                timeout_hit;

  logic                trk_act_q, trk_act_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  // Round-robin search starting just after the last winner.
  always_comb begin : winner
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (!win_found && bus.req_valid_i[k] && (k == (32'(ptr_q) + i) % N_REQ)) begin
          win_found = 1'b1;
          win_idx   = BANK_W'(k);
        end
      end
    end
  end

  always_comb begin : row_mux
    win_row = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (BANK_W'(k) == win_idx) win_row = bus.req_row_i[k*ROW_W +: ROW_W];
    end
  end

  // Ready is suppressed during a reset cycle so nothing is accepted and then dropped.
  assign ready_c = (state_q == IDLE && !rst_i && win_found) ? (N_REQ'(1) << win_idx) : '0;
  assign xfer    = |(ready_c & bus.req_valid_i);

`ifdef ACT_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt_q;

  // Counts elapsed WAIT cycles; zero on every WAIT entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != WAIT) wait_cnt_q <= '0;
    else                          wait_cnt_q <= wait_cnt_q + TO_W'(1);
  end

  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin : fsm_next
    state_d   = state_q;
    ptr_d     = ptr_q;
    row_d     = row_q;
    bank_d    = bank_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = ISSUE;
          ptr_d   = win_idx;
          row_d   = win_row;
          bank_d  = win_idx;
          grant_d = ready_c;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A done in the final WAIT cycle takes priority over the abort.
        if (bus.trk_done_i) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    trk_act_d = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin : fsm_reg
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= BANK_W'(N_REQ - 1);
      trk_act_q <= 1'b0;
      row_q     <= '0;
      bank_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      trk_act_q <= trk_act_d;
      row_q     <= row_d;
      bank_q    <= bank_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.req_ready_o = ready_c;
  assign bus.trk_act_o   = trk_act_q;
  assign bus.trk_row_o   = row_q;
  assign bus.trk_bank_o  = bank_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = busy_q;
  assign bus.act_cnt_o   = cnt_q;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_act_track_arbiter.sv
// Directed bench for act_track_arbiter: per-cycle vector table plus hand sequences.
// Expects TIMEOUT=8 behaviour when ACT_ARB_TIMEOUT_EN is defined.
module tb_act_track_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   acts;

  always #5 clk = ~clk;

  act_track_arbiter_if #(.N_REQ(4), .ROW_W(16), .BANK_W(2), .CNT_W(32)) bus ();

  act_track_arbiter #(
    .N_REQ(4), .ROW_W(16), .BANK_W(2), .CNT_W(32), .TIMEOUT(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic        d;
    logic [3:0]  rdy;
    logic        act;
    logic [1:0]  bank;
    logic        busy;
    logic [3:0]  grant;
    logic [31:0] cnt;
    logic [15:0] row;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(logic r, logic [3:0] v, logic d, logic [3:0] rdy, logic act,
                              logic [1:0] bank, logic busy, logic [3:0] grant,
                              logic [31:0] cnt, logic [15:0] row);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.rdy = rdy; x.act = act; x.bank = bank;
    x.busy = busy; x.grant = grant; x.cnt = cnt; x.row = row;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = '0;
    bus.req_row_i   = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    bus.trk_done_i  = 1'b0;

    // Tests 1/2: all valid, done two cycles after each ACT; then test 3: only req 2.
    vt[0]  = mk(1, 4'hF, 0, 4'h0, 0, 0, 0, 4'h0, 0, 16'h0000);
    vt[1]  = mk(0, 4'hF, 0, 4'h1, 0, 0, 0, 4'h0, 0, 16'h0000);
    vt[2]  = mk(0, 4'hF, 0, 4'h0, 1, 0, 1, 4'h1, 1, 16'h0010);
    vt[3]  = mk(0, 4'hF, 0, 4'h0, 0, 0, 1, 4'h1, 1, 16'h0010);
    vt[4]  = mk(0, 4'hF, 1, 4'h0, 0, 0, 1, 4'h1, 1, 16'h0010);
    vt[5]  = mk(0, 4'hF, 0, 4'h2, 0, 0, 0, 4'h0, 1, 16'h0010);
    vt[6]  = mk(0, 4'hF, 0, 4'h0, 1, 1, 1, 4'h2, 2, 16'h0011);
    vt[7]  = mk(0, 4'hF, 0, 4'h0, 0, 1, 1, 4'h2, 2, 16'h0011);
    vt[8]  = mk(0, 4'hF, 1, 4'h0, 0, 1, 1, 4'h2, 2, 16'h0011);
    vt[9]  = mk(0, 4'hF, 0, 4'h4, 0, 1, 0, 4'h0, 2, 16'h0011);
    vt[10] = mk(0, 4'hF, 0, 4'h0, 1, 2, 1, 4'h4, 3, 16'h0012);
    vt[11] = mk(0, 4'hF, 0, 4'h0, 0, 2, 1, 4'h4, 3, 16'h0012);
    vt[12] = mk(0, 4'hF, 1, 4'h0, 0, 2, 1, 4'h4, 3, 16'h0012);
    vt[13] = mk(0, 4'hF, 0, 4'h8, 0, 2, 0, 4'h0, 3, 16'h0012);
    vt[14] = mk(0, 4'hF, 0, 4'h0, 1, 3, 1, 4'h8, 4, 16'h0013);
    vt[15] = mk(0, 4'hF, 0, 4'h0, 0, 3, 1, 4'h8, 4, 16'h0013);
    vt[16] = mk(0, 4'hF, 1, 4'h0, 0, 3, 1, 4'h8, 4, 16'h0013);
    vt[17] = mk(0, 4'hF, 0, 4'h1, 0, 3, 0, 4'h0, 4, 16'h0013);
    vt[18] = mk(0, 4'hF, 0, 4'h0, 1, 0, 1, 4'h1, 5, 16'h0010);
    vt[19] = mk(0, 4'hF, 1, 4'h0, 0, 0, 1, 4'h1, 5, 16'h0010);
    vt[20] = mk(0, 4'h4, 0, 4'h4, 0, 0, 0, 4'h0, 5, 16'h0010);
    vt[21] = mk(0, 4'h4, 0, 4'h0, 1, 2, 1, 4'h4, 6, 16'h0012);
    vt[22] = mk(0, 4'h4, 1, 4'h0, 0, 2, 1, 4'h4, 6, 16'h0012);
    vt[23] = mk(0, 4'h4, 0, 4'h4, 0, 2, 0, 4'h0, 6, 16'h0012);
    vt[24] = mk(0, 4'h4, 0, 4'h0, 1, 2, 1, 4'h4, 7, 16'h0012);
    vt[25] = mk(0, 4'h4, 1, 4'h0, 0, 2, 1, 4'h4, 7, 16'h0012);
    vt[26] = mk(0, 4'h0, 0, 4'h0, 0, 2, 0, 4'h0, 7, 16'h0012);
    vt[27] = mk(0, 4'h0, 0, 4'h0, 0, 2, 0, 4'h0, 7, 16'h0012);

    repeat (2) @(posedge clk);
    #2;

    for (int i = 0; i < 28; i++) begin
      rst             = vt[i].r;
      bus.req_valid_i = vt[i].v;
      bus.trk_done_i  = vt[i].d;
      #1;
      chk($sformatf("v%0d.ready", i), 64'(bus.req_ready_o), 64'(vt[i].rdy));
      chk($sformatf("v%0d.act", i),   64'(bus.trk_act_o),   64'(vt[i].act));
      chk($sformatf("v%0d.bank", i),  64'(bus.trk_bank_o),  64'(vt[i].bank));
      chk($sformatf("v%0d.busy", i),  64'(bus.busy_o),      64'(vt[i].busy));
      chk($sformatf("v%0d.grant", i), 64'(bus.grant_o),     64'(vt[i].grant));
      chk($sformatf("v%0d.cnt", i),   64'(bus.act_cnt_o),   64'(vt[i].cnt));
      chk($sformatf("v%0d.row", i),   64'(bus.trk_row_o),   64'(vt[i].row));
      chk($sformatf("v%0d.tmo", i),   64'(bus.timeout_o),   64'd0);
      next_cycle();
    end

    // Test 4: done during ISSUE is ignored; WAIT holds until the later done.
    acts = 0;
    bus.req_valid_i = 4'b0001;
    #1;
    chk("t4.ready", 64'(bus.req_ready_o), 64'h1);
    next_cycle();
    bus.trk_done_i = 1'b1;
    #1;
    chk("t4.issue_act", 64'(bus.trk_act_o), 64'd1);
    chk("t4.issue_row", 64'(bus.trk_row_o), 64'h10);
    chk("t4.issue_cnt", 64'(bus.act_cnt_o), 64'd8);
    if (bus.trk_act_o) acts++;
    next_cycle();
    bus.trk_done_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4.wait%0d_busy", k), 64'(bus.busy_o), 64'd1);
      chk($sformatf("t4.wait%0d_ready", k), 64'(bus.req_ready_o), 64'd0);
      if (bus.trk_act_o) acts++;
      next_cycle();
    end
    bus.trk_done_i  = 1'b1;
    bus.req_valid_i = 4'b0000;
    #1;
    chk("t4.done_busy", 64'(bus.busy_o), 64'd1);
    if (bus.trk_act_o) acts++;
    next_cycle();
    bus.trk_done_i = 1'b0;
    #1;
    chk("t4.idle_busy", 64'(bus.busy_o), 64'd0);
    chk("t4.idle_grant", 64'(bus.grant_o), 64'd0);
    chk("t4.acts", 64'(acts), 64'd1);
    next_cycle();

    // Test 5: tracker never answers.
    bus.req_valid_i = 4'b0010;
    #1;
    chk("t5.ready", 64'(bus.req_ready_o), 64'h2);
    next_cycle();
    bus.req_valid_i = 4'b0000;
    #1;
    chk("t5.issue_bank", 64'(bus.trk_bank_o), 64'd1);
    chk("t5.issue_cnt", 64'(bus.act_cnt_o), 64'd9);
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t5.wait%0d_busy", k), 64'(bus.busy_o), 64'd1);
      chk($sformatf("t5.wait%0d_tmo", k), 64'(bus.timeout_o), 64'd0);
      next_cycle();
    end
`ifdef ACT_ARB_TIMEOUT_EN
    #1;
    chk("t5.abort_busy", 64'(bus.busy_o), 64'd0);
    chk("t5.abort_tmo", 64'(bus.timeout_o), 64'd1);
    chk("t5.abort_grant", 64'(bus.grant_o), 64'd0);
    next_cycle();
    #1;
    chk("t5.after_tmo", 64'(bus.timeout_o), 64'd0);
    chk("t5.after_cnt", 64'(bus.act_cnt_o), 64'd9);
    next_cycle();
`else
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t5.hold%0d_busy", k), 64'(bus.busy_o), 64'd1);
      chk($sformatf("t5.hold%0d_tmo", k), 64'(bus.timeout_o), 64'd0);
      next_cycle();
    end
    bus.trk_done_i = 1'b1;
    next_cycle();
    bus.trk_done_i = 1'b0;
    #1;
    chk("t5.end_busy", 64'(bus.busy_o), 64'd0);
    chk("t5.end_cnt", 64'(bus.act_cnt_o), 64'd9);
    next_cycle();
`endif

    // Test 6: reset while req 3 owns the tracker.
    bus.req_valid_i = 4'b1000;
    #1;
    chk("t6.ready", 64'(bus.req_ready_o), 64'h8);
    next_cycle();
    #1;
    chk("t6.issue_bank", 64'(bus.trk_bank_o), 64'd3);
    chk("t6.issue_row", 64'(bus.trk_row_o), 64'h13);
    next_cycle();
    #1;
    chk("t6.wait_grant", 64'(bus.grant_o), 64'h8);
    next_cycle();
    rst = 1'b1;
    bus.req_valid_i = 4'b1111;
    #1;
    chk("t6.rst_ready", 64'(bus.req_ready_o), 64'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("t6.post_busy", 64'(bus.busy_o), 64'd0);
    chk("t6.post_grant", 64'(bus.grant_o), 64'd0);
    chk("t6.post_cnt", 64'(bus.act_cnt_o), 64'd0);
    chk("t6.post_row", 64'(bus.trk_row_o), 64'd0);
    chk("t6.post_ready", 64'(bus.req_ready_o), 64'h1);
    next_cycle();
    #1;
    chk("t6.first_act", 64'(bus.trk_act_o), 64'd1);
    chk("t6.first_bank", 64'(bus.trk_bank_o), 64'd0);
    chk("t6.first_cnt", 64'(bus.act_cnt_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
